popcount_sequencer: RTL

//  Time-multiplexed population counter over a WIDTH-bit bit-vector (one bit per stochastic lane).

---
 rtl/popcount_pkg.sv | 20 ++
 rtl/popcount_sequencer_adder_tree.sv | 14 +
 rtl/popcount_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/popcount_pkg.sv
// Shared types and constants for the time-multiplexed population counter.
// The lane width is the nibble size that the single adder tree reduces each beat.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } pc_state_t;

    localparam int LANE_W = 4;

    // Beat counter width; a single-beat configuration still needs one bit.
    function automatic int beat_width(input int width);
        int n_beats;
        n_beats = width / LANE_W;
        return (n_beats > 1) ? $clog2(n_beats) : 1;
    endfunction

endpackage

// File: rtl/popcount_sequencer_adder_tree.sv
// Zero-latency 4-input adder tree: counts the ones in one nibble (result 0..4).
module adder_tree_4 (
    input  logic [3:0] i_bits,
    output logic [2:0] o_sum
);

    logic [1:0] w_pair_lo;
    logic [1:0] w_pair_hi;

    assign w_pair_lo = {1'b0, i_bits[0]} + {1'b0, i_bits[1]};
    assign w_pair_hi = {1'b0, i_bits[2]} + {1'b0, i_bits[3]};
    assign o_sum     = {1'b0, w_pair_lo} + {1'b0, w_pair_hi};

endmodule

// File: rtl/popcount_sequencer.sv
// Population counter that feeds one nibble per cycle through a shared adder tree
// and accumulates a running total; one result per WIDTH/4+2 cycles.
//
// state | meaning
// IDLE  | waiting for a vector (in_ready high once out of reset)
// ACCUM | adding one nibble per cycle into the accumulator
// DONE  | out_sum valid, held until the consumer takes it
module popcount_sequencer
    import popcount_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int SUM_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum
);

    localparam int N_BEATS = WIDTH / LANE_W;
    localparam int BEAT_W  = beat_width(WIDTH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

    generate
        if ((WIDTH % LANE_W) != 0 || WIDTH < LANE_W) begin : g_bad_width
            $error("popcount_sequencer: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    pc_state_t         r_state;
    pc_state_t         w_state_nxt;
    logic              r_live;
    logic [WIDTH-1:0]  r_shreg;
    logic [SUM_W-1:0]  r_acc;
    logic [BEAT_W-1:0] r_beat;
    logic [2:0]        w_tree_sum;
    logic              w_accept;
    logic              w_last_beat;

    adder_tree_4 u_tree (
        .i_bits (r_shreg[LANE_W-1:0]),
        .o_sum  (w_tree_sum)
    );

    // r_live keeps in_ready low for as long as nRST is held and one edge beyond.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    assign in_ready    = r_live && (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign out_sum     = r_acc;
    assign w_accept    = in_valid && in_ready && !clear;
    assign w_last_beat = (r_beat == LAST_BEAT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_last_beat) begin
                        w_state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_shreg <= '0;
            r_acc   <= '0;
            r_beat  <= '0;
        end else if (clear) begin
            r_shreg <= '0;
            r_acc   <= '0;
            r_beat  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shreg <= in_bits;
                        r_acc   <= '0;
                        r_beat  <= '0;
                    end
                end
                ACCUM: begin
                    r_acc   <= r_acc + SUM_W'(w_tree_sum);
                    r_shreg <= r_shreg >> LANE_W;
                    r_beat  <= r_beat + BEAT_W'(1);
                end
                default: begin
                    // DONE holds the result stable under backpressure.
                end
            endcase
        end
    end

endmodule
